game_timer: RTL

Stopwatch/countdown stage that consumes the 0.1 ms strobe produced by the game's clock-divider stage and turns it into a BCD mm:ss.cc time value for the score/time display. Counts up (elapsed play time) or down (round time limit) under start/pause/clear control. Issues a single-cycle timeout pulse on reaching 00:00.00 in countdown or 99:59.99 in count-up.

---
 rtl/game_timer_pkg.sv | 31 +++
 rtl/game_timer_if.sv | 25 ++
 rtl/game_timer_bcd_digit_step.sv | 38 +++
 rtl/game_timer.sv | 115 +++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game_timer stopwatch/countdown stage.
// Pure declarations and helpers; no latency, no flow control.
// Clamp helper keeps externally supplied preset digits inside legal BCD ranges.
package game_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]  DIGIT_MAX    = 4'd9;
    localparam logic [3:0]  TENS_SEC_MAX = 4'd5;
    localparam logic [23:0] TIME_ZERO    = 24'h000000;
    localparam logic [23:0] TIME_FULL    = 24'h995999;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

    // {m1,m0,s1,s0} preset -> full mm:ss.cc value with hundredths zeroed
    function automatic logic [23:0] preset_to_time(input logic [15:0] p);
        return {clamp_digit(p[15:12], DIGIT_MAX),
                clamp_digit(p[11:8],  DIGIT_MAX),
                clamp_digit(p[7:4],   TENS_SEC_MAX),
                clamp_digit(p[3:0],   DIGIT_MAX),
                8'h00};
    endfunction

endpackage

// File: rtl/game_timer_if.sv
// Control/status bundle between the game sequencer (master) and game_timer (slave).
// Wires only; no latency, no flow control.
// Commands are single-cycle strobes; status is registered in the timer.
interface game_timer_if;
    logic        tick_01ms;
    logic        start;
    logic        pause;
    logic        clear;
    logic        down;
    logic [15:0] preset;
    logic [23:0] time_bcd;
    logic        running;
    logic        expired;
    logic        timeout;

    modport master (
        output tick_01ms, start, pause, clear, down, preset,
        input  time_bcd, running, expired, timeout
    );

    modport slave (
        input  tick_01ms, start, pause, clear, down, preset,
        output time_bcd, running, expired, timeout
    );
endinterface

// File: rtl/game_timer_bcd_digit_step.sv
// Single BCD digit increment (dir=0) or decrement (dir=1) with carry/borrow out.
// Combinational, zero latency; no flow control.
// Digit passes through unchanged when enable is low.
module bcd_digit_step
    import game_timer_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic [3:0] digit,
    input  logic       enable,
    input  logic       dir,
    output logic [3:0] digit_nxt,
    output logic       carry
);

    always_comb begin
        digit_nxt = digit;
        carry     = 1'b0;
        if (enable) begin
            if (dir) begin
                if (digit == 4'd0) begin
                    digit_nxt = MAX;
                    carry     = 1'b1;
                end else begin
                    digit_nxt = digit - 4'd1;
                end
            end else begin
                if (digit == MAX) begin
                    digit_nxt = 4'd0;
                    carry     = 1'b1;
                end else begin
                    digit_nxt = digit + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/game_timer.sv
// BCD mm:ss.cc stopwatch/countdown driven by the 0.1 ms strobe, with start/pause/clear control.
// Commands and time steps are visible one cycle after the sampling edge; outputs registered.
// No backpressure: strobes arriving outside RUN are dropped and the prescaler holds.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int TICKS_PER_CS = 100
) (
    input  logic          clk,
    input  logic          reset,
    game_timer_if.slave   bus
);

    localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_CS - 1);
    localparam logic [3:0] LIMITS [6] = '{DIGIT_MAX, DIGIT_MAX, DIGIT_MAX,
                                          TENS_SEC_MAX, DIGIT_MAX, DIGIT_MAX};

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [7:0]  presc_q, presc_d;
    logic [23:0] time_q, time_d, time_step;
    logic        timeout_q, timeout_d;
    logic        running_q, expired_q;
    logic [6:0]  chain;

    // Ripple chain c0 -> m1; chain[6] out of m1 means the up count would overflow 99:59.99
    assign chain[0] = 1'b1;

    for (genvar i = 0; i < 6; i++) begin : g_digit
        bcd_digit_step #(.MAX(LIMITS[i])) u_step (
            .digit     (time_q[4*i +: 4]),
            .enable    (chain[i]),
            .dir       (mode_q),
            .digit_nxt (time_step[4*i +: 4]),
            .carry     (chain[i+1])
        );
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        presc_d   = presc_q;
        time_d    = time_q;
        timeout_d = 1'b0;

        if (bus.clear) begin
            state_d = ST_IDLE;
            presc_d = 8'd0;
            mode_d  = bus.down;
            time_d  = bus.down ? preset_to_time(bus.preset) : TIME_ZERO;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else if (bus.tick_01ms) begin
                        if (presc_q == PRESC_LAST) begin
                            presc_d = 8'd0;
                            if (!mode_q) begin
                                if (chain[6]) begin
                                    state_d   = ST_DONE;
                                    timeout_d = 1'b1;
                                end else begin
                                    time_d = time_step;
                                end
                            end else begin
                                time_d = time_step;
                                if (time_step == TIME_ZERO) begin
                                    state_d   = ST_DONE;
                                    timeout_d = 1'b1;
                                end
                            end
                        end else begin
                            presc_d = presc_q + 8'd1;
                        end
                    end
                end
                ST_IDLE, ST_PAUSE: begin
                    // A countdown with nothing left on the clock must not start
                    if (bus.start && !(bus.down && time_q == TIME_ZERO)) begin
                        state_d = ST_RUN;
                        mode_d  = bus.down;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            presc_q   <= 8'd0;
            time_q    <= TIME_ZERO;
            timeout_q <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            time_q    <= time_d;
            timeout_q <= timeout_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_DONE);
        end
    end

    assign bus.time_bcd = time_q;
    assign bus.running  = running_q;
    assign bus.expired  = expired_q;
    assign bus.timeout  = timeout_q;

endmodule
